regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 10 +
 rtl/wb_fifo.sv | 74 +++++++
 rtl/regfile_writeback.sv | 96 +++++++++
 tb/tb_regfile_writeback.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared widths and defaults for the register-file writeback buffer.
package regfile_writeback_pkg;

   localparam int unsigned XLEN_DEFAULT  = 32;
   localparam int unsigned REG_AW        = 5;
   localparam int unsigned DEPTH_DEFAULT = 2;

   typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO: storage, pointers and occupancy count, with entries
// also presented in age order (index 0 = oldest) for the forwarding compare.
module wb_fifo
   import regfile_writeback_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic [REG_AW-1:0]                push_rd,
   input  logic [XLEN-1:0]                  push_data,
   input  logic                             pop,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(DEPTH):0]           count,
   output logic [DEPTH-1:0]                 ord_vld,
   output logic [DEPTH-1:0][REG_AW-1:0]     ord_rd,
   output logic [DEPTH-1:0][XLEN-1:0]       ord_data
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [REG_AW-1:0] mem_rd   [DEPTH];
   logic [XLEN-1:0]   mem_data [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; every consumer gates it with ord_vld.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_rd[wr_ptr]   <= push_rd;
         mem_data[wr_ptr] <= push_data;
      end
   end

   always_comb begin
      ord_vld  = '0;
      ord_rd   = '0;
      ord_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ord_vld[i]  = (CW'(i) < count);
         ord_rd[i]   = mem_rd[rd_ptr + PW'(i)];
         ord_data[i] = mem_data[rd_ptr + PW'(i)];
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates load/ALU results into a pending-write FIFO,
// drains it to the register file and forwards pending values to operands.
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [REG_AW-1:0]       ld_rd,
   input  logic [XLEN-1:0]         ld_data,
   input  logic                    alu_valid,
   output logic                    alu_ready,
   input  logic [REG_AW-1:0]       alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    rf_busy,
   output logic                    rf_we,
   output logic [REG_AW-1:0]       rf_w_addr,
   output logic [XLEN-1:0]         rf_w_data,
   input  logic [REG_AW-1:0]       fwd_addr1,
   input  logic [REG_AW-1:0]       fwd_addr2,
   output logic                    fwd_hit1,
   output logic                    fwd_hit2,
   output logic [XLEN-1:0]         fwd_data1,
   output logic [XLEN-1:0]         fwd_data2,
   output logic [$clog2(DEPTH):0]  pending
);

   logic                         full;
   logic                         empty;
   logic                         ld_fire;
   logic                         alu_fire;
   logic                         push;
   logic                         pop;
   logic [REG_AW-1:0]            push_rd;
   logic [XLEN-1:0]              push_data;
   logic [DEPTH-1:0]             ord_vld;
   logic [DEPTH-1:0][REG_AW-1:0] ord_rd;
   logic [DEPTH-1:0][XLEN-1:0]   ord_data;

   // Load wins arbitration; ready comes from the registered full flag only.
   assign ld_ready  = !full;
   assign alu_ready = !full && !ld_valid;
   assign ld_fire   = ld_valid && ld_ready;
   assign alu_fire  = alu_valid && alu_ready;
   assign push_rd   = ld_fire ? ld_rd   : alu_rd;
   assign push_data = ld_fire ? ld_data : alu_data;

   // Writes to x0 are handshaken but never buffered.
   assign push = (ld_fire || alu_fire) && (push_rd != '0);
   assign pop  = !empty && !rf_busy;

   assign rf_we     = pop;
   assign rf_w_addr = ord_vld[0] ? ord_rd[0]   : '0;
   assign rf_w_data = ord_vld[0] ? ord_data[0] : '0;

   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ord_vld[i] && (fwd_addr1 != '0) && (ord_rd[i] == fwd_addr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = ord_data[i];
         end
         if (ord_vld[i] && (fwd_addr2 != '0) && (ord_rd[i] == fwd_addr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = ord_data[i];
         end
      end
   end

   wb_fifo #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_rd   (push_rd),
      .push_data (push_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (pending),
      .ord_vld   (ord_vld),
      .ord_rd    (ord_rd),
      .ord_data  (ord_data)
   );

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, reset corner case and
// randomized traffic against a queue-based reference model.
module tb_regfile_writeback;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        ld_valid, alu_valid, rf_busy;
   logic        ld_ready, alu_ready, rf_we;
   logic [4:0]  ld_rd, alu_rd, rf_w_addr, fwd_addr1, fwd_addr2;
   logic [31:0] ld_data, alu_data, rf_w_data, fwd_data1, fwd_data2;
   logic        fwd_hit1, fwd_hit2;
   logic [1:0]  pending;

   regfile_writeback #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .rf_busy   (rf_busy),
      .rf_we     (rf_we),
      .rf_w_addr (rf_w_addr),
      .rf_w_data (rf_w_data),
      .fwd_addr1 (fwd_addr1),
      .fwd_addr2 (fwd_addr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic lv; logic [4:0] lrd; logic [31:0] ldat;
      logic av; logic [4:0] ard; logic [31:0] adat;
      logic busy; logic [4:0] fa1; logic [4:0] fa2;
      logic e_lr; logic e_ar; logic e_we; logic [4:0] e_addr; logic [31:0] e_data;
      logic e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2; logic [1:0] e_pend;
   } row_t;

   typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

   int   n_pass = 0;
   int   n_total = 0;
   row_t tbl[15];
   ent_t mq[$];
   int   acc_nz = 0;
   int   n_writes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic row_t mkr(int lv, int lrd, int ldat, int av, int ard, int adat,
                                int busy, int fa1, int fa2, int lr, int ar, int we,
                                int addr, int data, int h1, int d1, int h2, int d2, int pend);
      row_t r;
      r.lv = 1'(lv);  r.lrd = 5'(lrd); r.ldat = 32'(ldat);
      r.av = 1'(av);  r.ard = 5'(ard); r.adat = 32'(adat);
      r.busy = 1'(busy); r.fa1 = 5'(fa1); r.fa2 = 5'(fa2);
      r.e_lr = 1'(lr); r.e_ar = 1'(ar); r.e_we = 1'(we);
      r.e_addr = 5'(addr); r.e_data = 32'(data);
      r.e_h1 = 1'(h1); r.e_d1 = 32'(d1); r.e_h2 = 1'(h2); r.e_d2 = 32'(d2);
      r.e_pend = 2'(pend);
      return r;
   endfunction

   task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic busy, input logic [4:0] fa1, input logic [4:0] fa2);
      ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
      alu_valid = av; alu_rd = ard; alu_data = adat;
      rf_busy = busy; fwd_addr1 = fa1; fwd_addr2 = fa2;
   endtask

   task automatic apply_row(input int k, input row_t r);
      @(negedge clk);
      drive(r.lv, r.lrd, r.ldat, r.av, r.ard, r.adat, r.busy, r.fa1, r.fa2);
      #1;
      chk($sformatf("row%0d.ld_ready", k),  64'(ld_ready),  64'(r.e_lr));
      chk($sformatf("row%0d.alu_ready", k), 64'(alu_ready), 64'(r.e_ar));
      chk($sformatf("row%0d.rf_we", k),     64'(rf_we),     64'(r.e_we));
      chk($sformatf("row%0d.rf_w_addr", k), 64'(rf_w_addr), 64'(r.e_addr));
      chk($sformatf("row%0d.rf_w_data", k), 64'(rf_w_data), 64'(r.e_data));
      chk($sformatf("row%0d.fwd_hit1", k),  64'(fwd_hit1),  64'(r.e_h1));
      chk($sformatf("row%0d.fwd_data1", k), 64'(fwd_data1), 64'(r.e_d1));
      chk($sformatf("row%0d.fwd_hit2", k),  64'(fwd_hit2),  64'(r.e_h2));
      chk($sformatf("row%0d.fwd_data2", k), 64'(fwd_data2), 64'(r.e_d2));
      chk($sformatf("row%0d.pending", k),   64'(pending),   64'(r.e_pend));
   endtask

   // Reference: a bounded queue; forward from the youngest match, drain the oldest.
   task automatic model_cycle(input int c, input logic lv, input logic [4:0] lrd,
                              input logic [31:0] ldat, input logic av, input logic [4:0] ard,
                              input logic [31:0] adat, input logic busy,
                              input logic [4:0] fa1, input logic [4:0] fa2);
      bit          full, e_lr, e_ar, e_we, h1, h2;
      logic [31:0] d1, d2;
      ent_t        head;
      @(negedge clk);
      drive(lv, lrd, ldat, av, ard, adat, busy, fa1, fa2);
      #1;
      full = (mq.size() == DEPTH);
      e_lr = !full;
      e_ar = !full && !lv;
      e_we = (mq.size() > 0) && !busy;
      h1 = 0; h2 = 0; d1 = 0; d2 = 0;
      foreach (mq[i]) begin
         if (fa1 != 0 && mq[i].rd == fa1) begin h1 = 1; d1 = mq[i].d; end
         if (fa2 != 0 && mq[i].rd == fa2) begin h2 = 1; d2 = mq[i].d; end
      end
      chk($sformatf("rnd%0d.ld_ready", c),  64'(ld_ready),  64'(e_lr));
      chk($sformatf("rnd%0d.alu_ready", c), 64'(alu_ready), 64'(e_ar));
      chk($sformatf("rnd%0d.rf_we", c),     64'(rf_we),     64'(e_we));
      if (e_we) begin
         head = mq[0];
         chk($sformatf("rnd%0d.rf_w_addr", c), 64'(rf_w_addr), 64'(head.rd));
         chk($sformatf("rnd%0d.rf_w_data", c), 64'(rf_w_data), 64'(head.d));
      end
      chk($sformatf("rnd%0d.fwd_hit1", c),  64'(fwd_hit1),  64'(h1));
      chk($sformatf("rnd%0d.fwd_data1", c), 64'(fwd_data1), 64'(d1));
      chk($sformatf("rnd%0d.fwd_hit2", c),  64'(fwd_hit2),  64'(h2));
      chk($sformatf("rnd%0d.fwd_data2", c), 64'(fwd_data2), 64'(d2));
      chk($sformatf("rnd%0d.pending", c),   64'(pending),   64'(mq.size()));
      if (rf_we) n_writes++;
      if (e_we) void'(mq.pop_front());
      if (lv && e_lr) begin
         if (lrd != 0) begin mq.push_back('{lrd, ldat}); acc_nz++; end
      end else if (av && e_ar) begin
         if (ard != 0) begin mq.push_back('{ard, adat}); acc_nz++; end
      end
   endtask

   initial begin
      // Directed sequences: single load, ld/alu collision, stalled full buffer, x0 drop.
      tbl[0]  = mkr(1,5,'hDEADBEEF, 0,0,0,    0, 5,0,  1,0,0, 0,0,          0,0,          0,0,   0);
      tbl[1]  = mkr(0,0,0,          0,0,0,    0, 5,0,  1,1,1, 5,'hDEADBEEF, 1,'hDEADBEEF, 0,0,   1);
      tbl[2]  = mkr(0,0,0,          0,0,0,    0, 5,0,  1,1,0, 0,0,          0,0,          0,0,   0);
      tbl[3]  = mkr(1,3,'h11,       1,4,'h22, 0, 3,0,  1,0,0, 0,0,          0,0,          0,0,   0);
      tbl[4]  = mkr(0,0,0,          1,4,'h22, 0, 3,4,  1,1,1, 3,'h11,       1,'h11,       0,0,   1);
      tbl[5]  = mkr(0,0,0,          0,0,0,    0, 4,4,  1,1,1, 4,'h22,       1,'h22,       1,'h22,1);
      tbl[6]  = mkr(0,0,0,          0,0,0,    0, 4,0,  1,1,0, 0,0,          0,0,          0,0,   0);
      tbl[7]  = mkr(1,7,'h1,        0,0,0,    1, 7,0,  1,0,0, 0,0,          0,0,          0,0,   0);
      tbl[8]  = mkr(0,0,0,          1,7,'h2,  1, 7,0,  1,1,0, 7,'h1,        1,'h1,        0,0,   1);
      tbl[9]  = mkr(0,0,0,          0,0,0,    1, 7,7,  0,0,0, 7,'h1,        1,'h2,        1,'h2, 2);
      tbl[10] = mkr(1,9,'h99,       0,0,0,    0, 7,0,  0,0,1, 7,'h1,        1,'h2,        0,0,   2);
      tbl[11] = mkr(0,0,0,          0,0,0,    0, 7,9,  1,1,1, 7,'h2,        1,'h2,        0,0,   1);
      tbl[12] = mkr(0,0,0,          0,0,0,    0, 7,9,  1,1,0, 0,0,          0,0,          0,0,   0);
      tbl[13] = mkr(0,0,0,          1,0,'hFFFF,0,0,0,  1,1,0, 0,0,          0,0,          0,0,   0);
      tbl[14] = mkr(0,0,0,          0,0,0,    0, 0,0,  1,1,0, 0,0,          0,0,          0,0,   0);

      rst_n = 1'b0;
      drive(1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2);
      #7;
      chk("reset.rf_we",     64'(rf_we),     64'd0);
      chk("reset.pending",   64'(pending),   64'd0);
      chk("reset.ld_ready",  64'(ld_ready),  64'd1);
      chk("reset.alu_ready", 64'(alu_ready), 64'd0);
      chk("reset.fwd_hit1",  64'(fwd_hit1),  64'd0);
      ld_valid = 1'b0;
      #1;
      chk("reset.alu_ready_idle", 64'(alu_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 15; k++) apply_row(k, tbl[k]);

      // Fill under stall, then pulse reset mid-cycle and confirm nothing drains.
      @(negedge clk); drive(1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0);
      @(negedge clk); drive(1'b1, 5'd11, 32'hB, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0);
      @(negedge clk); drive(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0);
      #1;
      chk("full.pending",  64'(pending),  64'd2);
      chk("full.ld_ready", 64'(ld_ready), 64'd0);
      #2;
      rf_busy  = 1'b0;
      ld_valid = 1'b1;
      rst_n    = 1'b0;
      #1;
      chk("midrst.rf_we",     64'(rf_we),     64'd0);
      chk("midrst.pending",   64'(pending),   64'd0);
      chk("midrst.ld_ready",  64'(ld_ready),  64'd1);
      chk("midrst.alu_ready", 64'(alu_ready), 64'd0);
      chk("midrst.fwd_hit1",  64'(fwd_hit1),  64'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         chk($sformatf("postrst%0d.rf_we", k),   64'(rf_we),   64'd0);
         chk($sformatf("postrst%0d.pending", k), 64'(pending), 64'd0);
      end

      // Alternating ld/alu traffic with random stalls, occasional collisions and x0.
      for (int c = 0; c < 64; c++) begin
         logic lv, av, busy;
         lv   = ((c % 2) == 0) || ($urandom_range(0, 3) == 0);
         av   = ((c % 2) == 1) || ($urandom_range(0, 3) == 0);
         busy = ($urandom_range(0, 2) == 0);
         model_cycle(c, lv, 5'($urandom_range(0, 7)), $urandom,
                     av, 5'($urandom_range(0, 7)), $urandom,
                     busy, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      for (int c = 64; c < 64 + DEPTH + 2; c++)
         model_cycle(c, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      chk("rnd.writes_vs_accepted", 64'(n_writes), 64'(acc_nz));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
